// File: rtl/bin_counter_pkg.sv
// bin_counter_pkg: shared modes and parameter legality check for the binary counter family.
package bin_counter_pkg;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;
   function automatic bit range_ok(input int n, input longint m);
      return n >= 1 && n <= 32 && m >= 2 && m <= (longint'(1) << n);
   endfunction
endpackage

// File: rtl/bin_next_val.sv
// bin_next_val: combinational next count, wrap and load range flag for a mod-MOD counter.
module bin_next_val
   import bin_counter_pkg::*;
#(
   parameter int     N        = 4,
   parameter longint MOD      = 16,
   parameter int     SATURATE = MODE_WRAP
) (
   input  logic [N-1:0] i_q,
   input  logic [N-1:0] i_d,
   input  logic         i_up,
   input  logic         i_en,
   input  logic         i_load_n,
   output logic [N-1:0] o_next,
   output logic         o_wrap,
   output logic         o_load_err,
   output logic         o_at_end
);
   // One extra bit keeps MOD-1 and D comparisons exact when MOD == 2**N.
   localparam logic [N:0] MAXV = (N+1)'(MOD - 1);
   logic [N:0] w_q, w_d, w_cnt;
   logic       w_sat, w_range;
   assign w_q      = {1'b0, i_q};
   assign w_d      = {1'b0, i_d};
   assign w_sat    = (SATURATE == MODE_SAT);
   assign w_range  = w_d > MAXV;
   assign o_at_end = i_up ? (w_q == MAXV) : (w_q == '0);
   assign w_cnt    = o_at_end ? (w_sat ? w_q : (i_up ? '0 : MAXV))
                              : (i_up ? w_q + (N+1)'(1) : w_q - (N+1)'(1));
   assign o_next   = N'(!i_load_n ? (w_range ? MAXV : w_d) : (i_en ? w_cnt : w_q));
   assign o_wrap     = i_load_n & i_en & o_at_end & !w_sat;
   assign o_load_err = !i_load_n & w_range;
endmodule

// File: rtl/bin_updown_modn.sv
// bin_updown_modn: mod-MOD up/down counter with load, enable, wrap/saturate and cascadable tc.
module bin_updown_modn
   import bin_counter_pkg::*;
#(
   parameter int     N        = 4,
   parameter longint MOD      = 16,
   parameter int     SATURATE = MODE_WRAP
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         load_n,
   input  logic         en,
   input  logic         up,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q,
   output logic         tc,
   output logic         wrap,
   output logic         load_err
);
   if (!range_ok(N, MOD)) begin : g_bad_param
      $error("bin_updown_modn: illegal N/MOD combination");
   end
   logic [N-1:0] r_q, w_next;
   logic         r_wrap, r_load_err, w_wrap, w_load_err, w_at_end;
   bin_next_val #(.N(N), .MOD(MOD), .SATURATE(SATURATE)) u_next (
      .i_q(r_q), .i_d(D), .i_up(up), .i_en(en), .i_load_n(load_n),
      .o_next(w_next), .o_wrap(w_wrap), .o_load_err(w_load_err), .o_at_end(w_at_end)
   );
   always_ff @(posedge clk) begin
      if (!clear) begin
         r_q        <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_q        <= w_next;
         r_wrap     <= w_wrap;
         r_load_err <= w_load_err;
      end
   end
   assign Q        = r_q;
   assign wrap     = r_wrap;
   assign load_err = r_load_err;
   assign tc       = clear & en & w_at_end;
endmodule

// File: tb/tb_bin_updown_modn.sv
// tb_bin_updown_modn: directed checks of wrap, saturate and cascaded mod-10 counters against a behavioural model.
module tb_bin_updown_modn;
   localparam int M = 10;
   logic clk = 0;
   always #5 clk = ~clk;
   logic       clear = 0, load_n = 0, en = 1, up = 1;
   logic [3:0] d = 4'd5;
   logic       c_load_n = 1, c_en0 = 0, c_up = 1;
   logic [3:0] c_d0 = 0, c_d1 = 0;
   logic [3:0] q [4];
   logic       w [4], le [4], tc [4];
   int tests = 0, fails = 0;
   bin_updown_modn #(.N(4), .MOD(M), .SATURATE(0)) u_w (.clk(clk), .clear(clear), .load_n(load_n),
      .en(en), .up(up), .D(d), .Q(q[0]), .tc(tc[0]), .wrap(w[0]), .load_err(le[0]));
   bin_updown_modn #(.N(4), .MOD(M), .SATURATE(1)) u_s (.clk(clk), .clear(clear), .load_n(load_n),
      .en(en), .up(up), .D(d), .Q(q[1]), .tc(tc[1]), .wrap(w[1]), .load_err(le[1]));
   bin_updown_modn #(.N(4), .MOD(M), .SATURATE(0)) u_c0 (.clk(clk), .clear(clear), .load_n(c_load_n),
      .en(c_en0), .up(c_up), .D(c_d0), .Q(q[2]), .tc(tc[2]), .wrap(w[2]), .load_err(le[2]));
   bin_updown_modn #(.N(4), .MOD(M), .SATURATE(0)) u_c1 (.clk(clk), .clear(clear), .load_n(c_load_n),
      .en(tc[2]), .up(c_up), .D(c_d1), .Q(q[3]), .tc(tc[3]), .wrap(w[3]), .load_err(le[3]));

   int mq [4];
   bit mw [4], mle [4];
   bit mvalid = 0;

   function automatic bit mtc(input int qv, input bit cl, input bit e, input bit u);
      return cl && e && (u ? qv == M - 1 : qv == 0);
   endfunction

   task automatic mstep(input int qv, input bit ld_n, input bit e, input bit u, input int dv,
                        input bit sat, output int nq, output bit nw, output bit nle);
      nq = qv; nw = 0; nle = 0;
      if (!ld_n) begin
         nle = dv >= M;
         nq  = nle ? M - 1 : dv;
      end else if (e) begin
         if (u) begin
            if (qv == M - 1) begin nq = sat ? qv : 0; nw = !sat; end
            else nq = qv + 1;
         end else begin
            if (qv == 0) begin nq = sat ? 0 : M - 1; nw = !sat; end
            else nq = qv - 1;
         end
      end
   endtask

   always @(posedge clk) begin
      bit t0;
      t0 = mtc(mq[2], clear, c_en0, c_up);
      if (!clear) begin
         for (int i = 0; i < 4; i++) begin mq[i] = 0; mw[i] = 0; mle[i] = 0; end
         mvalid = 1;
      end else begin
         mstep(mq[0], load_n, en, up, int'(d), 0, mq[0], mw[0], mle[0]);
         mstep(mq[1], load_n, en, up, int'(d), 1, mq[1], mw[1], mle[1]);
         mstep(mq[3], c_load_n, t0, c_up, int'(c_d1), 0, mq[3], mw[3], mle[3]);
         mstep(mq[2], c_load_n, c_en0, c_up, int'(c_d0), 0, mq[2], mw[2], mle[2]);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         for (int i = 0; i < 4; i++) begin
            bit e, u;
            e = (i < 2) ? en : (i == 2) ? c_en0 : mtc(mq[2], clear, c_en0, c_up);
            u = (i < 2) ? up : c_up;
            chk($sformatf("model_q%0d", i), int'(q[i]), mq[i]);
            chk($sformatf("model_wrap%0d", i), int'(w[i]), int'(mw[i]));
            chk($sformatf("model_lerr%0d", i), int'(le[i]), int'(mle[i]));
            chk($sformatf("model_tc%0d", i), int'(tc[i]), int'(mtc(mq[i], clear, e, u)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      chk("reset_q", int'(q[0]), 0);
      chk("reset_wrap", int'(w[0]), 0);
      chk("reset_lerr", int'(le[0]), 0);
      chk("reset_tc", int'(tc[0]), 0);
      clear = 1; load_n = 1; en = 1; up = 1;
      repeat (9) tick();
      chk("up9_q", int'(q[0]), 9);
      chk("up9_tc", int'(tc[0]), 1);
      chk("up9_model", mq[0], 9);
      tick();
      chk("wrap_q", int'(q[0]), 0);
      chk("wrap_pulse", int'(w[0]), 1);
      chk("sat_hold_q", int'(q[1]), 9);
      chk("sat_no_wrap", int'(w[1]), 0);
      tick();
      chk("wrap_one_cycle", int'(w[0]), 0);
      chk("after_wrap_q", int'(q[0]), 1);
      clear = 0;
      tick();
      clear = 1; up = 0;
      tick();
      chk("down_wrap_q", int'(q[0]), 9);
      chk("down_wrap_pulse", int'(w[0]), 1);
      chk("down_sat_q", int'(q[1]), 0);
      chk("down_sat_tc", int'(tc[1]), 1);
      chk("down_sat_wrap", int'(w[1]), 0);
      load_n = 0; d = 4'd7;
      tick();
      chk("load7_q", int'(q[0]), 7);
      chk("load7_lerr", int'(le[0]), 0);
      d = 4'd12;
      tick();
      chk("load12_q", int'(q[0]), 9);
      chk("load12_lerr", int'(le[0]), 1);
      chk("load12_nowrap", int'(w[0]), 0);
      load_n = 1; en = 0;
      for (int i = 0; i < 5; i++) begin
         up = ~up;
         tick();
         chk("hold_q", int'(q[0]), 9);
         chk("hold_tc", int'(tc[0]), 0);
         chk("hold_lerr", int'(le[0]), 0);
      end
      c_load_n = 0; c_d0 = 4'd8; c_d1 = 4'd9;
      tick();
      c_load_n = 1; c_en0 = 1; c_up = 1;
      chk("casc_load_lo", int'(q[2]), 8);
      chk("casc_load_hi", int'(q[3]), 9);
      tick();
      chk("casc99_tc0", int'(tc[2]), 1);
      tick();
      chk("casc00_lo", int'(q[2]), 0);
      chk("casc00_hi", int'(q[3]), 0);
      chk("casc00_wrap_hi", int'(w[3]), 1);
      c_up = 0;
      tick();
      chk("casc_down_lo", int'(q[2]), 9);
      chk("casc_down_hi", int'(q[3]), 9);
      chk("casc_down_model", mq[3], 9);
      c_en0 = 0;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
